pipeline_hazard_ctrl: RTL

- Central sequencer for the front of the 5-stage RISC-V pipeline.
- Drives PC write enable, IF/ID write/flush and ID/EX bubble insertion from:
  - load-use hazards
  - taken branches/jumps resolved in EX
  - instruction-memory not-ready
  - data-memory busy
- Small FSM handles multi-cycle memory waits (with watchdog) and multi-cycle branch redirect.

---
 rtl/pipeline_hazard_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: PC/IF-ID/ID-EX stall and flush sequencer for a 5-stage RISC-V pipeline.
// Define HAZARD_PERF_CNT_EN to add the saturating stallCount/flushCount outputs.
module pipeline_hazard_ctrl #(
    parameter int REDIRECT_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 255,
    parameter int CNT_W           = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] idRs1,
    input  logic [4:0] idRs2,
    input  logic       idUsesRs1,
    input  logic       idUsesRs2,
    input  logic [4:0] exRd,
    input  logic       exMemRead,
    input  logic       exBranchTaken,
    input  logic       imemReady,
    input  logic       dmemReady,
    output logic       pcWrite,
    output logic       ifIdWrite,
    output logic       ifIdFlush,
    output logic       idExFlush,
    output logic       stallActive,
    output logic       memTimeout
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stallCount,
    output logic [CNT_W-1:0] flushCount
`endif
);
    localparam int WW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WW-1:0] TMO = WW'(MEM_TIMEOUT);
    typedef enum logic [1:0] {RUN, MEM_WAIT, REDIRECT} state_t;
    state_t state_q, state_d;
    logic [3:0] redir_cnt_q, redir_cnt_d;
    logic [WW-1:0] wait_cnt_q, wait_cnt_d;
    logic ret_redir_q, ret_redir_d, mem_timeout_q, mem_timeout_d;
    logic pc_w, ifid_w, ifid_f, idex_f, load_use, redir_mode;
    assign load_use = exMemRead && exRd != 5'd0 &&
                      ((idUsesRs1 && idRs1 == exRd) || (idUsesRs2 && idRs2 == exRd));
    // A memory wait entered from REDIRECT resumes the redirect sequence on release.
    assign redir_mode = state_q == REDIRECT || (state_q == MEM_WAIT && ret_redir_q);
    always_comb begin
        state_d     = state_q;
        redir_cnt_d = redir_cnt_q;
        wait_cnt_d  = '0;
        ret_redir_d = 1'b0;
        pc_w        = 1'b0;
        ifid_w      = 1'b0;
        ifid_f      = 1'b0;
        idex_f      = 1'b0;
        if (!dmemReady) begin
            state_d     = MEM_WAIT;
            wait_cnt_d  = state_q != MEM_WAIT ? WW'(1) :
                          wait_cnt_q == TMO ? wait_cnt_q : wait_cnt_q + 1'b1;
            ret_redir_d = state_q == MEM_WAIT ? ret_redir_q : state_q == REDIRECT;
        end else if (redir_mode) begin
            pc_w        = imemReady;
            ifid_w      = 1'b1;
            ifid_f      = 1'b1;
            state_d     = imemReady && redir_cnt_q == 4'd1 ? RUN : REDIRECT;
            redir_cnt_d = imemReady ? redir_cnt_q - 4'd1 : redir_cnt_q;
        end else if (exBranchTaken) begin
            pc_w        = 1'b1;
            ifid_w      = 1'b1;
            ifid_f      = 1'b1;
            idex_f      = 1'b1;
            state_d     = REDIRECT_CYCLES > 0 ? REDIRECT : RUN;
            redir_cnt_d = 4'(REDIRECT_CYCLES);
        end else begin
            pc_w    = !load_use && imemReady;
            ifid_w  = !load_use;
            ifid_f  = !load_use && !imemReady;
            idex_f  = load_use;
            state_d = RUN;
        end
        mem_timeout_d = mem_timeout_q || (!dmemReady && wait_cnt_d == TMO);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            redir_cnt_q   <= '0;
            wait_cnt_q    <= '0;
            ret_redir_q   <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            redir_cnt_q   <= redir_cnt_d;
            wait_cnt_q    <= wait_cnt_d;
            ret_redir_q   <= ret_redir_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end
    assign pcWrite     = !rst && pc_w;
    assign ifIdWrite   = !rst && ifid_w;
    assign ifIdFlush   = rst || ifid_f;
    assign idExFlush   = rst || idex_f;
    assign stallActive = !pcWrite || !ifIdWrite;
    assign memTimeout  = mem_timeout_q;
`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;
    always_comb begin
        stall_cnt_d = stall_cnt_q + CNT_W'(stallActive && !(&stall_cnt_q));
        flush_cnt_d = flush_cnt_q + CNT_W'(idExFlush && !(&flush_cnt_q));
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign stallCount = stall_cnt_q;
    assign flushCount = flush_cnt_q;
`endif
endmodule
